// File: rtl/iob_csr_resp_pkg.sv
// rtl/iob_csr_resp_pkg.sv - shared types and default widths for the IOb CSR responder
package iob_csr_resp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NREGS  = 4;
    localparam int STRB_W     = DEF_DATA_W / 8;

    // Bus-side FSM: IDLE accepts requests, RESP holds a read beat until taken
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // Number of byte strobes for a given data width
    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/iob_csr_resp_if.sv
// rtl/iob_csr_resp_if.sv - IOb-native request/response bus bundle
interface iob_csr_resp_if
    import iob_csr_resp_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic                           iob_valid_i;
    logic [ADDR_W-1:0]              iob_addr_i;
    logic [DATA_W-1:0]              iob_wdata_i;
    logic [strb_width(DATA_W)-1:0]  iob_wstrb_i;
    logic                           iob_ready_o;
    logic                           iob_rvalid_o;
    logic [DATA_W-1:0]              iob_rdata_o;
    logic                           iob_rready_i;

    modport master (
        output iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i, iob_rready_i,
        input  iob_ready_o, iob_rvalid_o, iob_rdata_o
    );

    modport slave (
        input  iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i, iob_rready_i,
        output iob_ready_o, iob_rvalid_o, iob_rdata_o
    );

endinterface

// File: rtl/iob_csr_resp_reg.sv
// rtl/iob_csr_resp_reg.sv - one CSR with soft clear, byte-strobed bus write and hw write
module iob_csr_resp_reg
    import iob_csr_resp_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    localparam int               SW      = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic              clr_i,
    input  logic [SW-1:0]     bus_strb_i,
    input  logic [DATA_W-1:0] bus_data_i,
    input  logic              hw_we_i,
    input  logic [DATA_W-1:0] hw_data_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] d;

    // Per byte lane: bus strobe wins, otherwise hw write, otherwise hold
    always_comb begin
        d = q_o;
        for (int b = 0; b < SW; b++) begin
            if (bus_strb_i[b]) begin
                d[b*8 +: 8] = bus_data_i[b*8 +: 8];
            end else if (hw_we_i) begin
                d[b*8 +: 8] = hw_data_i[b*8 +: 8];
            end
        end
    end

    // Clock-enabled register; soft clear overrides any write in the same cycle
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            q_o <= RST_VAL;
        end else if (cke_i) begin
            if (clr_i) begin
                q_o <= RST_VAL;
            end else begin
                q_o <= d;
            end
        end
    end

endmodule

// File: rtl/iob_csr_resp.sv
// rtl/iob_csr_resp.sv - IOb bus responder exposing NREGS software-visible registers
module iob_csr_resp
    import iob_csr_resp_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                NREGS   = DEF_NREGS,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    arst_i,
    input  logic                    rst_i,
    iob_csr_resp_if.slave           bus,
    input  logic [NREGS-1:0]        hw_we_i,
    input  logic [NREGS*DATA_W-1:0] hw_data_i,
    output logic [NREGS*DATA_W-1:0] regs_o
);

    localparam int SW    = DATA_W / 8;
    localparam int IDX_W = ADDR_W - 2;

    state_t            state_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] q [NREGS];
    logic [DATA_W-1:0] rd_word;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              wr_acc;
    logic              unused_addr_lsb;

    assign idx             = bus.iob_addr_i[ADDR_W-1:2];
    assign unused_addr_lsb = ^bus.iob_addr_i[1:0];
    assign accept          = cke_i && (state_q == IDLE) && bus.iob_valid_i;
    assign wr_acc          = accept && (|bus.iob_wstrb_i);

    assign bus.iob_ready_o  = (state_q == IDLE);
    assign bus.iob_rvalid_o = rvalid_q;
    assign bus.iob_rdata_o  = rdata_q;

    // Register bank; bus strobes reach only the addressed register, so
    // out-of-range writes fall through and change nothing
    for (genvar k = 0; k < NREGS; k++) begin : g_reg
        logic [SW-1:0] strb;
        assign strb = (wr_acc && (idx == IDX_W'(k))) ? bus.iob_wstrb_i : '0;

        iob_csr_resp_reg #(
            .DATA_W  (DATA_W),
            .RST_VAL (RST_VAL)
        ) u_reg (
            .clk_i      (clk_i),
            .cke_i      (cke_i),
            .arst_i     (arst_i),
            .clr_i      (rst_i),
            .bus_strb_i (strb),
            .bus_data_i (bus.iob_wdata_i),
            .hw_we_i    (hw_we_i[k]),
            .hw_data_i  (hw_data_i[k*DATA_W +: DATA_W]),
            .q_o        (q[k])
        );

        assign regs_o[k*DATA_W +: DATA_W] = q[k];
    end

    // Read mux over current flop values; unimplemented indices read as zero
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (idx == IDX_W'(k)) begin
                rd_word = q[k];
            end
        end
    end

    // Response FSM; soft clear deliberately leaves a pending beat intact
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (cke_i) begin
            case (state_q)
                IDLE: begin
                    if (bus.iob_valid_i && (bus.iob_wstrb_i == '0)) begin
                        state_q  <= RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_word;
                    end
                end
                RESP: begin
                    if (bus.iob_rready_i) begin
                        state_q  <= IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_csr_resp.sv
// tb/tb_iob_csr_resp.sv - directed self-checking bench for iob_csr_resp
module tb_iob_csr_resp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 3;

    logic                    clk;
    logic                    cke;
    logic                    arst;
    logic                    rst;
    logic [NREGS-1:0]        hw_we;
    logic [NREGS*DATA_W-1:0] hw_data;
    logic [NREGS*DATA_W-1:0] regs;

    int tests;
    int fails;

    iob_csr_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    iob_csr_resp #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NREGS   (NREGS),
        .RST_VAL ('0)
    ) dut (
        .clk_i     (clk),
        .cke_i     (cke),
        .arst_i    (arst),
        .rst_i     (rst),
        .bus       (bus.slave),
        .hw_we_i   (hw_we),
        .hw_data_i (hw_data),
        .regs_o    (regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.iob_valid_i = 1'b0;
        bus.iob_addr_i  = '0;
        bus.iob_wdata_i = '0;
        bus.iob_wstrb_i = '0;
    endtask

    task automatic req(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.iob_valid_i = 1'b1;
        bus.iob_addr_i  = a;
        bus.iob_wdata_i = d;
        bus.iob_wstrb_i = s;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cke = 1'b1;
        arst = 1'b1;
        rst = 1'b0;
        hw_we = '0;
        hw_data = '0;
        idle_bus();
        bus.iob_rready_i = 1'b0;
        step();
        step();
        arst = 1'b0;
        #1;

        // 1: reset state
        chk("rst_regs",   regs, 0);
        chk("rst_ready",  bus.iob_ready_o, 1);
        chk("rst_rvalid", bus.iob_rvalid_o, 0);
        chk("rst_rdata",  bus.iob_rdata_o, 0);

        // 2: full write reg1, then read with 1-cycle latency
        req(4'h4, 32'hDEADBEEF, 4'hF);
        step();
        chk("wr_reg1", regs[63:32], 32'hDEADBEEF);
        chk("wr_no_rvalid", bus.iob_rvalid_o, 0);
        req(4'h4, 32'h0, 4'h0);
        bus.iob_rready_i = 1'b1;
        step();
        idle_bus();
        chk("rd1_rvalid", bus.iob_rvalid_o, 1);
        chk("rd1_rdata",  bus.iob_rdata_o, 32'hDEADBEEF);
        chk("rd1_ready",  bus.iob_ready_o, 0);
        step();
        chk("rd1_rvalid_drop", bus.iob_rvalid_o, 0);
        chk("rd1_ready_back",  bus.iob_ready_o, 1);

        // 3: partial byte write
        req(4'h0, 32'h11223344, 4'hF);
        step();
        req(4'h0, 32'hAABBCCDD, 4'h2);
        step();
        idle_bus();
        chk("strb_reg0", regs[31:0], 32'h1122CC44);

        // cke low freezes writes
        cke = 1'b0;
        req(4'h0, 32'h99999999, 4'hF);
        step();
        idle_bus();
        chk("cke_freeze", regs[31:0], 32'h1122CC44);
        cke = 1'b1;

        // 4: held response while rready low
        bus.iob_rready_i = 1'b0;
        req(4'h0, 32'h0, 4'h0);
        step();
        idle_bus();
        for (int i = 0; i < 3; i++) begin
            chk("hold_ready",  bus.iob_ready_o, 0);
            chk("hold_rvalid", bus.iob_rvalid_o, 1);
            chk("hold_rdata",  bus.iob_rdata_o, 32'h1122CC44);
            step();
        end
        bus.iob_rready_i = 1'b1;
        step();
        chk("hold_rel_rvalid", bus.iob_rvalid_o, 0);
        chk("hold_rel_ready",  bus.iob_ready_o, 1);
        bus.iob_rready_i = 1'b0;

        // 5: bus/hw collision on reg1, plain hw write on reg2
        req(4'h4, 32'h000000FF, 4'h1);
        hw_we = 3'b110;
        hw_data = {32'hCAFEF00D, 32'h12345600, 32'h0};
        step();
        idle_bus();
        hw_we = '0;
        chk("coll_reg1", regs[63:32], 32'h123456FF);
        chk("hw_reg2",   regs[95:64], 32'hCAFEF00D);
        chk("coll_reg0", regs[31:0],  32'h1122CC44);
        req(4'h4, 32'h0, 4'h0);
        step();
        idle_bus();
        chk("pend_rdata", bus.iob_rdata_o, 32'h123456FF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("clr_regs",   regs, 0);
        chk("clr_rvalid", bus.iob_rvalid_o, 1);
        chk("clr_rdata",  bus.iob_rdata_o, 32'h123456FF);
        bus.iob_rready_i = 1'b1;
        step();
        chk("clr_rel", bus.iob_rvalid_o, 0);

        // soft clear beats a same-cycle bus write
        req(4'h0, 32'h55555555, 4'hF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_bus();
        chk("clr_over_wr", regs[31:0], 0);

        // 6: out-of-range index
        req(4'h8, 32'hA5A5A5A5, 4'hF);
        step();
        req(4'hC, 32'h0, 4'h0);
        step();
        idle_bus();
        chk("oor_rvalid", bus.iob_rvalid_o, 1);
        chk("oor_rdata",  bus.iob_rdata_o, 0);
        step();
        chk("oor_rel", bus.iob_rvalid_o, 0);
        req(4'hC, 32'hFFFFFFFF, 4'hF);
        step();
        idle_bus();
        chk("oor_wr", regs, {32'hA5A5A5A5, 32'h0, 32'h0});

        // async reset drops a pending response
        bus.iob_rready_i = 1'b0;
        req(4'h8, 32'h0, 4'h0);
        step();
        idle_bus();
        chk("ar_pre_rvalid", bus.iob_rvalid_o, 1);
        #2;
        arst = 1'b1;
        #1;
        chk("ar_rvalid", bus.iob_rvalid_o, 0);
        chk("ar_ready",  bus.iob_ready_o, 1);
        chk("ar_regs",   regs, 0);
        arst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iob_csr_resp.md
Name: iob_csr_resp

Overview:
IOb-native bus responder that exposes NREGS software-visible registers to a CPU/initiator.
- Handles the bus side of register access: write strobes, read response with hold-until-accepted handshake.
- Also accepts per-register hardware updates and a synchronous soft clear.
- Sits between the system interconnect and a peripheral core (e.g. cache control/status), complementing the plain hardware registers used inside the core.

Parameters:
DATA_W, 32, register and bus data width in bits (multiple of 8)
ADDR_W, 4, bus byte-address width; word index = iob_addr_i[ADDR_W-1:2]
NREGS, 4, number of implemented registers (1..2**(ADDR_W-2))
RST_VAL, 0, reset and clear value of every register (DATA_W bits)

Ports:
clk_i  input  1  clock
cke_i  input  1  clock enable; low freezes all state
arst_i  input  1  asynchronous reset, active-high
rst_i  input  1  synchronous soft clear, active-high
iob_valid_i  input  1  request valid
iob_addr_i  input  ADDR_W  byte address
iob_wdata_i  input  DATA_W  write data
iob_wstrb_i  input  DATA_W/8  byte strobes; all-zero = read
iob_ready_o  output  1  request accepted this cycle
iob_rvalid_o  output  1  read data valid
iob_rdata_o  output  DATA_W  read data
iob_rready_i  input  1  initiator accepts read data
hw_we_i  input  NREGS  per-register hardware write enable
hw_data_i  input  NREGS*DATA_W  hardware write data, reg k at [k*DATA_W +: DATA_W]
regs_o  output  NREGS*DATA_W  current register contents, same packing

Behaviour:
- Reset values (arst_i high, async): all registers = RST_VAL; iob_rvalid_o=0; iob_rdata_o=0; FSM=IDLE.
  - iob_ready_o is combinational = (state==IDLE); it reads 1 after reset.
- One clock, single async active-high reset arst_i; everything else is synchronous to clk_i and qualified by cke_i.
- FSM states:
  - IDLE: ready=1. A request is accepted when iob_valid_i is high.
    - Write (wstrb!=0): update bytes where strobe=1 in word index idx; stay in IDLE. No response beat.
    - Read (wstrb==0): capture the register into rdata, set rvalid next cycle, go to RESP.
  - RESP: ready=0; rvalid=1; rdata held stable. Go to IDLE on the cycle iob_rready_i=1; rvalid falls the next cycle.
- Read latency: exactly 1 cycle from acceptance to rvalid. A back-to-back read is possible the cycle after RESP exits.
- Read data is the register value before any same-cycle update.
- Out-of-range index (idx>=NREGS): reads return 0 with normal handshake; writes are accepted and ignored.
- Register update priority per cycle: rst_i (all regs := RST_VAL) > bus write > hw_we_i[k].
  - On a bus/hardware collision, only the byte lanes with the strobe set take bus data; the rest take hw_data.
- rst_i does not affect the FSM or a pending response. An outstanding rvalid/rdata survives a soft clear.
- arst_i mid-RESP: response dropped immediately; rvalid=0.
- cke_i=0: no state change, no acceptance. iob_ready_o is still driven from state; initiators must not count a beat while cke_i=0.
- regs_o reflects register flops directly (no extra latency).

Decomposition:
- Shared package/header: IDLE/RESP state encodings, a STRB_W=DATA_W/8 constant, and the default widths.
- Natural sub-module: iob_csr_resp_reg, a single register with byte-strobed bus write, hw write and sync clear priority mux.
  - Instantiated NREGS times via generate.
  - Built on the codebase's clock-enabled async-reset register primitive.

Test Plan:
1. After arst_i pulse: regs_o all 0, iob_ready_o=1, iob_rvalid_o=0.
2. Write addr 0x4, wdata 0xDEADBEEF, wstrb 0xF. Then read addr 0x4 with iob_rready_i=1 → rvalid exactly 1 cycle after acceptance, rdata=0xDEADBEEF, regs_o[63:32]=0xDEADBEEF.
3. Write 0x11223344 to reg0 with wstrb 0xF, then wstrb 0x2 with wdata 0xAABBCCDD → reg0=0x1122CC44.
4. Read reg0 with iob_rready_i low for 3 cycles → ready=0, rvalid=1, rdata stable for all 3 cycles. Raise rready → rvalid drops next cycle, ready=1.
5. Same cycle: bus write reg1 wstrb 0x1 wdata 0xFF, hw_we_i[1]=1 hw_data 0x12345600 → reg1=0x123456FF. Next cycle rst_i=1 → all regs = RST_VAL, pending rvalid unaffected.
6. Read addr 0xC with NREGS=3 → rdata=0, normal handshake. Write to it → no reg changes.
